if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The parameter list SHALL be exactly: DEPTH, 2, number of buffered fetch entries (power of two, >= 2).
REQ-002 The port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and act as the asynchronous active-low reset.
REQ-004 The port if_valid SHALL be an input, 1 bit wide, and indicate that fetch presents an instruction this cycle.
REQ-005 The port if_instr SHALL be an input, 16 bits wide, and carry the fetched instruction word.
REQ-006 The port if_pc_inc SHALL be an input, 16 bits wide, and carry the PC+1 value belonging to if_instr.
REQ-007 The port if_ready SHALL be an output, 1 bit wide, and indicate that the queue accepts a push; fetch drives its stall input from !if_ready.
REQ-008 The port flush SHALL be an input, 1 bit wide, and indicate that a taken Call, Branch or Ret squashes all queued and incoming instructions.
REQ-009 The port id_valid SHALL be an output, 1 bit wide, and indicate that the head entry is presented to decode.
REQ-010 The port id_instr SHALL be an output, 16 bits wide, and carry the head instruction, or NOP when id_valid=0.
REQ-011 The port id_pc_inc SHALL be an output, 16 bits wide, and carry the head PC+1 value, or 16'h0000 when id_valid=0.
REQ-012 The port id_ready SHALL be an input, 1 bit wide, and indicate that decode consumes the head this cycle (low on hazard stall).
REQ-013 The port count SHALL be an output, $clog2(DEPTH+1) bits wide, and report the current occupancy.

Function
REQ-014 push SHALL equal if_valid & if_ready & !flush, and pop SHALL equal id_valid & id_ready & !flush.
REQ-015 The queue SHALL operate as a circular FIFO using wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide, which wrap modulo DEPTH without any special case.
REQ-016 if_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state, with no combinational path from id_ready.
REQ-017 id_valid SHALL equal (count != 0), and id_instr/id_pc_inc SHALL be read combinationally from entry rd_ptr.
REQ-018 Latency: an entry pushed at edge N SHALL be visible on id_* from edge N, i.e. one cycle after if_valid; there SHALL be no empty-queue bypass.
REQ-019 Occupancy states SHALL be EMPTY (count=0), PARTIAL and FULL (count=DEPTH).
REQ-020 In EMPTY, push only is allowed. In PARTIAL, push, pop or both are allowed. In FULL, pop only is allowed.
REQ-021 A simultaneous push and pop SHALL leave count unchanged while advancing both pointers.
REQ-022 A push while FULL cannot occur, because if_ready is low, and a pop while EMPTY cannot occur, because id_valid is low; no overflow or underflow SHALL be possible.
REQ-023 When flush=1, the next edge SHALL set count to 0 and wr_ptr and rd_ptr to 0, and SHALL discard the same-cycle push and pop regardless of id_ready or if_valid.
REQ-024 flush SHALL take priority over every other event; entry storage need not be cleared on flush.
REQ-025 Data fields SHALL pass through unmodified, with no width conversion or arithmetic on if_pc_inc.

Reset
REQ-026 While rst_n=0, count, wr_ptr and rd_ptr SHALL be 0 and all storage entries SHALL be 16'h0000, asynchronously.
REQ-027 While rst_n=0, the outputs SHALL be id_valid=0, id_instr=NOP, id_pc_inc=16'h0000, if_ready=1 and count=0.
REQ-028 A reset asserted mid-operation SHALL drop all entries immediately, without waiting for a clock edge.
REQ-029 Normal operation SHALL begin at the first rising clk edge after rst_n deasserts.

Structure
REQ-030 The shared package cpu_pkg SHALL hold INSTR_W=16, PC_W=16, NOP_INSTR=16'h0000, and the typedefs instr_t and pc_t.
REQ-031 DEPTH SHALL remain a local parameter of this module and SHALL NOT be placed in the package.
REQ-032 There SHALL be no sub-module; storage, pointers and count SHALL be inline, in one module of roughly 120-200 lines.

Verification
REQ-033 The bench SHALL check reset values: with rst_n low mid-stream while count=2, id_valid=0, count=0 and if_ready=1 asynchronously, before the next clk edge.
REQ-034 The bench SHALL check fill and stall: push A=16'h1111 and B=16'h2222 with id_ready=0, giving count=2, if_ready=0, and id_instr=16'h1111 held.
REQ-035 The bench SHALL check drain order: releasing id_ready after the fill gives id_instr 16'h1111 then 16'h2222, then id_valid=0 and id_instr=16'h0000.
REQ-036 The bench SHALL check simultaneous push/pop: at count=1, if_valid=1 and id_ready=1 for 6 cycles keep count=1 throughout, deliver data in order, and wrap the pointers at least twice.
REQ-037 The bench SHALL check flush priority: at count=2 with if_valid=1 and id_ready=1 and flush=1, the next cycle has count=0 and id_valid=0, and the flushed push never appears.
REQ-038 The bench SHALL check back-to-back flush then push: flush at cycle N and push 16'h3333 at N+1 give id_instr=16'h3333 with count=1 at N+2.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU-wide widths, constants and basic types.
//   INSTR_W   : instruction word width
//   PC_W      : program counter width
//   NOP_INSTR : encoding presented to decode when no instruction is valid
//   instr_t   : instruction word type
//   pc_t      : program counter type
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [PC_W-1:0]    pc_t;

  localparam instr_t NOP_INSTR = 16'h0000;

endpackage : cpu_pkg

// File: rtl/if_id_queue.sv
// if_id_queue -- circular instruction queue between fetch and decode.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   if_valid  : fetch presents an instruction this cycle
//   if_instr  : fetched instruction word
//   if_pc_inc : PC+1 belonging to if_instr
//   if_ready  : queue accepts a push (fetch stalls on !if_ready)
//   flush     : taken Call/Branch/Ret, squashes queued and incoming entries
//   id_valid  : head entry is presented to decode
//   id_instr  : head instruction, NOP when id_valid=0
//   id_pc_inc : head PC+1, zero when id_valid=0
//   id_ready  : decode consumes the head this cycle
//   count     : current occupancy
//
// An entry pushed at edge N is visible on id_* right after edge N; there is
// no bypass around an empty queue. if_ready and id_valid come only from the
// registered count, so neither handshake combinationally depends on the other
// side.
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_valid,
  input  instr_t                     if_instr,
  input  pc_t                        if_pc_inc,
  output logic                       if_ready,
  input  logic                       flush,
  output logic                       id_valid,
  output instr_t                     id_instr,
  output pc_t                        id_pc_inc,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    instr_t instr;
    pc_t    pc_inc;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  occ_e               occ;
  logic               push;
  logic               pop;

  // Occupancy decode from registered count only.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q == CNT_W'(DEPTH)) begin
      occ = OCC_FULL;
    end
  end

  assign if_ready = (occ != OCC_FULL);
  assign id_valid = (occ != OCC_EMPTY);

  // Flush masks both handshakes, so the same-cycle push/pop are discarded.
  assign push = if_valid & if_ready & ~flush;
  assign pop  = id_valid & id_ready & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Storage is left as is; a zero count makes it unreachable.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: if_instr, pc_inc: if_pc_inc};
        // DEPTH is a power of two, so the pointer wraps naturally.
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign id_instr  = id_valid ? mem_q[rd_ptr_q].instr  : NOP_INSTR;
  assign id_pc_inc = id_valid ? mem_q[rd_ptr_q].pc_inc : pc_t'(0);
  assign count     = count_q;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue -- directed bench for if_id_queue (DEPTH=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_if_id_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk;
  logic             rst_n;
  logic             if_valid;
  instr_t           if_instr;
  pc_t              if_pc_inc;
  logic             if_ready;
  logic             flush;
  logic             id_valid;
  instr_t           id_instr;
  pc_t              id_pc_inc;
  logic             id_ready;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc_inc (if_pc_inc),
    .if_ready  (if_ready),
    .flush     (flush),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc_inc (id_pc_inc),
    .id_ready  (id_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input instr_t ins, input pc_t pc,
                       input logic rdy, input logic fl);
    if_valid  = v;
    if_instr  = ins;
    if_pc_inc = pc;
    id_ready  = rdy;
    flush     = fl;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #12;
    // Reset state
    check_val("rst_id_valid", 32'(id_valid), 32'd0);
    check_val("rst_count",    32'(count),    32'd0);
    check_val("rst_if_ready", 32'(if_ready), 32'd1);
    check_val("rst_id_instr", 32'(id_instr), 32'h0000);
    check_val("rst_id_pc",    32'(id_pc_inc), 32'h0000);
    tick();
    rst_n = 1'b1;

    // Fill and stall
    drive(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0);
    tick();
    check_val("fill1_count",  32'(count),    32'd1);
    check_val("fill1_instr",  32'(id_instr), 32'h1111);
    check_val("fill1_valid",  32'(id_valid), 32'd1);
    check_val("fill1_ready",  32'(if_ready), 32'd1);
    drive(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0);
    tick();
    check_val("fill2_count",  32'(count),    32'd2);
    check_val("fill2_ready",  32'(if_ready), 32'd0);
    check_val("fill2_instr",  32'(id_instr), 32'h1111);
    check_val("fill2_pc",     32'(id_pc_inc), 32'h0001);
    // Push offered while full is not accepted
    drive(1'b1, 16'h9999, 16'h0009, 1'b0, 1'b0);
    tick();
    check_val("full_count",   32'(count),    32'd2);
    check_val("full_instr",   32'(id_instr), 32'h1111);

    // Drain order
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    check_val("drain1_instr", 32'(id_instr), 32'h2222);
    check_val("drain1_pc",    32'(id_pc_inc), 32'h0002);
    check_val("drain1_count", 32'(count),    32'd1);
    tick();
    check_val("drain2_valid", 32'(id_valid), 32'd0);
    check_val("drain2_instr", 32'(id_instr), 32'h0000);
    check_val("drain2_pc",    32'(id_pc_inc), 32'h0000);
    check_val("drain2_count", 32'(count),    32'd0);

    // Simultaneous push/pop at count=1
    drive(1'b1, 16'h5000, 16'h5100, 1'b0, 1'b0);
    tick();
    check_val("pp_pre_count", 32'(count),    32'd1);
    check_val("pp_pre_instr", 32'(id_instr), 32'h5000);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, instr_t'(16'h5000 + i), pc_t'(16'h5100 + i), 1'b1, 1'b0);
      tick();
      check_val($sformatf("pp%0d_count", i), 32'(count),     32'd1);
      check_val($sformatf("pp%0d_instr", i), 32'(id_instr),  32'h5000 + 32'(i));
      check_val($sformatf("pp%0d_pc", i),    32'(id_pc_inc), 32'h5100 + 32'(i));
    end

    // Flush priority at count=2
    drive(1'b1, 16'h6000, 16'h6100, 1'b0, 1'b0);
    tick();
    check_val("fl_pre_count", 32'(count),    32'd2);
    check_val("fl_pre_instr", 32'(id_instr), 32'h5006);
    drive(1'b1, 16'h7777, 16'h7778, 1'b1, 1'b1);
    tick();
    check_val("fl_count",     32'(count),    32'd0);
    check_val("fl_valid",     32'(id_valid), 32'd0);
    check_val("fl_instr",     32'(id_instr), 32'h0000);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    check_val("fl_post_count", 32'(count),    32'd0);
    check_val("fl_post_valid", 32'(id_valid), 32'd0);

    // Flush at count=1 discards a push that would otherwise be accepted
    drive(1'b1, 16'h6200, 16'h6201, 1'b0, 1'b0);
    tick();
    check_val("fl1_pre_count", 32'(count), 32'd1);
    drive(1'b1, 16'h7878, 16'h7879, 1'b0, 1'b1);
    tick();
    check_val("fl1_count",    32'(count),    32'd0);
    check_val("fl1_instr",    32'(id_instr), 32'h0000);

    // Back-to-back flush then push
    drive(1'b1, 16'h4444, 16'h4445, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();
    check_val("b2b_n_count",  32'(count),    32'd0);
    drive(1'b1, 16'h3333, 16'h3334, 1'b0, 1'b0);
    tick();
    check_val("b2b_instr",    32'(id_instr), 32'h3333);
    check_val("b2b_pc",       32'(id_pc_inc), 32'h3334);
    check_val("b2b_count",    32'(count),    32'd1);

    // Asynchronous reset mid-stream at count=2
    drive(1'b1, 16'h8888, 16'h8889, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check_val("ar_pre_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_valid",     32'(id_valid), 32'd0);
    check_val("ar_count",     32'(count),    32'd0);
    check_val("ar_ready",     32'(if_ready), 32'd1);
    check_val("ar_instr",     32'(id_instr), 32'h0000);
    check_val("ar_pc",        32'(id_pc_inc), 32'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("ar_post_count", 32'(count), 32'd0);
    drive(1'b1, 16'hABCD, 16'hABCE, 1'b0, 1'b0);
    tick();
    check_val("ar_push_instr", 32'(id_instr), 32'hABCD);
    check_val("ar_push_count", 32'(count),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_if_id_queue
